// File: rtl/text_writer.sv
// text_writer: character-console writer for the 40x30 text display memory.
// Accepts one ASCII byte per valid/ready handshake. It handles CR, LF, BS
// and FF, writes printable characters at the cursor, and blanks each newly
// entered row (or the whole screen on FF).
module text_writer #(
    parameter int COLS   = 40,
    parameter int ROWS   = 30,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              clr,
    input  logic [7:0]        in_dat,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_dat,
    output logic              mem_we,
    output logic [5:0]        cur_col,
    output logic [4:0]        cur_row,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        CLRLINE = 2'd2,
        CLRALL  = 2'd3
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;

    state_t            state, nxt_state;
    logic [5:0]        nxt_col;
    logic [4:0]        nxt_row;
    logic [ADDR_W-1:0] nxt_addr;
    logic [7:0]        nxt_dat;
    logic [ADDR_W-1:0] cnt, nxt_cnt;
    logic [4:0]        row_inc;

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] r, input logic [5:0] c);
        return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
    endfunction

    // Every non-IDLE state issues exactly one write per cycle, so the write
    // strobe is decoded from the state and drops at once on asynchronous reset.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign mem_we   = (state != IDLE);

    assign row_inc = (cur_row == 5'(ROWS - 1)) ? '0 : cur_row + 5'd1;

    // Registers for the state, the cursor, the write address/data and the clear counter.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            cur_col  <= '0;
            cur_row  <= '0;
            mem_addr <= '0;
            mem_dat  <= '0;
            cnt      <= '0;
        end else begin
            state    <= nxt_state;
            cur_col  <= nxt_col;
            cur_row  <= nxt_row;
            mem_addr <= nxt_addr;
            mem_dat  <= nxt_dat;
            cnt      <= nxt_cnt;
        end
    end

    // Next-state logic: byte decode in IDLE, cursor advance/wrap, clear sequencing.
    always_comb begin
        nxt_state = state;
        nxt_col   = cur_col;
        nxt_row   = cur_row;
        nxt_addr  = mem_addr;
        nxt_dat   = mem_dat;
        nxt_cnt   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_dat >= 8'h20 && in_dat <= 8'h7E) begin
                        nxt_state = WRITE;
                        nxt_addr  = cell_addr(cur_row, cur_col);
                        nxt_dat   = in_dat;
                    end else begin
                        case (in_dat)
                            8'h0A: begin
                                nxt_state = CLRLINE;
                                nxt_col   = '0;
                                nxt_row   = row_inc;
                                nxt_addr  = cell_addr(row_inc, '0);
                                nxt_dat   = SPACE;
                                nxt_cnt   = '0;
                            end
                            8'h0D: nxt_col = '0;
                            8'h08: begin
                                if (cur_col != '0) nxt_col = cur_col - 6'd1;
                            end
                            8'h0C: begin
                                nxt_state = CLRALL;
                                nxt_col   = '0;
                                nxt_row   = '0;
                                nxt_addr  = '0;
                                nxt_dat   = SPACE;
                                nxt_cnt   = '0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            WRITE: begin
                if (cur_col < 6'(COLS - 1)) begin
                    nxt_state = IDLE;
                    nxt_col   = cur_col + 6'd1;
                end else begin
                    nxt_state = CLRLINE;
                    nxt_col   = '0;
                    nxt_row   = row_inc;
                    nxt_addr  = cell_addr(row_inc, '0);
                    nxt_dat   = SPACE;
                    nxt_cnt   = '0;
                end
            end
            CLRLINE: begin
                if (cnt == ADDR_W'(COLS - 1)) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_addr = mem_addr + 1'b1;
                    nxt_cnt  = cnt + 1'b1;
                end
            end
            CLRALL: begin
                if (cnt == ADDR_W'(COLS * ROWS - 1)) begin
                    nxt_state = IDLE;
                end else begin
                    nxt_addr = mem_addr + 1'b1;
                    nxt_cnt  = cnt + 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

endmodule
